// File: rtl/maple_bus_sequencer.sv
// Half-duplex SDCKA/SDCKB scheduler: launches the frame transmitter, releases the pads
// after a turnaround gap and opens the reply window. Optional retry: MAPLE_SEQ_RETRY_EN.
module maple_bus_sequencer #(
  parameter int unsigned TURNAROUND_CYCLES    = 32,
  parameter int unsigned REPLY_TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_WIDTH            = 17
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic cmd_valid,
  input  logic cmd_expect_reply,
  output logic cmd_ready,
  output logic tx_start,
  input  logic tx_busy,
  output logic pad_oe,
  output logic rx_enable,
  input  logic rx_receiving,
  input  logic rx_done,
  output logic busy,
  output logic done_pulse,
  output logic timeout_pulse
);

  typedef enum logic [6:0] {
    S_IDLE       = 7'b0000001,
    S_WAIT_BUS   = 7'b0000010,
    S_TX_LAUNCH  = 7'b0000100,
    S_TX_ACTIVE  = 7'b0001000,
    S_TURNAROUND = 7'b0010000,
    S_WAIT_REPLY = 7'b0100000,
    S_RX_ACTIVE  = 7'b1000000
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TA_LAST  = CNT_WIDTH'(TURNAROUND_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(REPLY_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_t                 state_q, state_d;
  logic                   expect_q, expect_d;
  logic                   tx_seen_q, tx_seen_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
  logic                   tx_start_q, tx_start_d;
  logic                   pad_oe_q, pad_oe_d;
  logic                   rx_enable_q, rx_enable_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;
`ifdef MAPLE_SEQ_RETRY_EN
  logic [1:0]             retry_q, retry_d;
`endif

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    expect_d  = expect_q;
    tx_seen_d = tx_seen_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
`ifdef MAPLE_SEQ_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
`ifdef MAPLE_SEQ_RETRY_EN
        retry_d = 2'd0;
`endif
        if (cmd_valid && !rx_receiving) begin
          expect_d = cmd_expect_reply;
          state_d  = S_WAIT_BUS;
        end
      end
      S_WAIT_BUS: begin
        if (!rx_receiving) state_d = S_TX_LAUNCH;
      end
      S_TX_LAUNCH: begin
        // tx_busy may already answer in the launch cycle, so start tracking here.
        tx_seen_d = tx_busy;
        state_d   = S_TX_ACTIVE;
      end
      S_TX_ACTIVE: begin
        tx_seen_d = tx_seen_q | tx_busy;
        if (tx_seen_q && !tx_busy) begin
          if (expect_q) begin
            state_d = S_TURNAROUND;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_TURNAROUND: begin
        if (cnt_q == TA_LAST) begin
          state_d = S_WAIT_REPLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_REPLY: begin
        if (rx_receiving) begin
          state_d = S_RX_ACTIVE;
        end else if (cnt_q == TO_LAST) begin
`ifdef MAPLE_SEQ_RETRY_EN
          if (retry_q != 2'd2) begin
            retry_d = retry_q + 2'd1;
            state_d = S_WAIT_BUS;
          end else begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end
`else
          timeout_d = 1'b1;
          state_d   = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RX_ACTIVE: begin
        if (rx_done) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (!rx_receiving) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    tx_start_d  = (state_d == S_TX_LAUNCH);
    pad_oe_d    = (state_d inside {S_TX_LAUNCH, S_TX_ACTIVE});
    rx_enable_d = (state_d inside {S_WAIT_REPLY, S_RX_ACTIVE});
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      expect_q    <= 1'b0;
      tx_seen_q   <= 1'b0;
      cnt_q       <= '0;
      tx_start_q  <= 1'b0;
      pad_oe_q    <= 1'b0;
      rx_enable_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef MAPLE_SEQ_RETRY_EN
      retry_q     <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      expect_q    <= expect_d;
      tx_seen_q   <= tx_seen_d;
      cnt_q       <= cnt_d;
      tx_start_q  <= tx_start_d;
      pad_oe_q    <= pad_oe_d;
      rx_enable_q <= rx_enable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
`ifdef MAPLE_SEQ_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  // Handshake: a command is taken on a cycle where cmd_valid && cmd_ready; cmd_ready is
  // combinational so a command waiting on a foreign frame is taken the cycle it ends.
  assign cmd_ready     = aresetn && (state_q == S_IDLE) && !rx_receiving;
  assign tx_start      = tx_start_q;
  assign pad_oe        = pad_oe_q;
  assign rx_enable     = rx_enable_q;
  assign busy          = busy_q;
  assign done_pulse    = done_q;
  assign timeout_pulse = timeout_q;

  a_no_bus_fight: assert property (@(posedge aclk) !(pad_oe_q && rx_enable_q));

endmodule

// File: doc/maple_bus_sequencer.md
Name: maple_bus_sequencer

Overview:
Half-duplex scheduler for the shared SDCKA/SDCKB pair. It owns bus direction and turns the bus around between the frame transmitter and the frame receiver. It accepts one host command at a time, fires the transmitter, releases the pads after a turnaround gap, and then enables the receiver for the reply window. It reports reply, timeout or abort status to the host/DMA side.

Parameters:
TURNAROUND_CYCLES, 32, aclk cycles between tx_busy falling and rx_enable rising (pad release gap); minimum 1.
REPLY_TIMEOUT_CYCLES, 100000, aclk cycles allowed from rx_enable rising to first rx_receiving; minimum 1.
CNT_WIDTH, 17, counter width; must hold max(TURNAROUND_CYCLES, REPLY_TIMEOUT_CYCLES).

Ports:
aclk  in  1  clock
aresetn  in  1  reset: synchronous, active-low, sampled on the aclk rising edge
cmd_valid  in  1  host requests a transmission
cmd_expect_reply  in  1  qualifier sampled with cmd_valid; 1 means open a reply window after TX
cmd_ready  out  1  sequencer accepts a command (asserted only in IDLE)
tx_start  out  1  single-cycle pulse that starts the frame transmitter
tx_busy  in  1  transmitter is driving a frame
pad_oe  out  1  1 = this node drives SDCKA/SDCKB
rx_enable  out  1  drives the receiver ENABLE input
rx_receiving  in  1  receiver RECEIVING output
rx_done  in  1  pulse on the receiver's last accepted beat (TVALID & TREADY & TLAST)
busy  out  1  high in every state except IDLE
done_pulse  out  1  one-cycle pulse when a command completes successfully
timeout_pulse  out  1  one-cycle pulse when the reply window expires

Behaviour:
- Reset values: every output is 0 and the state is IDLE. Reset in any state returns to IDLE on the next edge, drops pad_oe and rx_enable in the same cycle, and clears all counters.
- One-hot FSM states: IDLE, WAIT_BUS, TX_LAUNCH, TX_ACTIVE, TURNAROUND, WAIT_REPLY, RX_ACTIVE.
- IDLE: cmd_ready=1.
  - On cmd_valid, latch cmd_expect_reply and go to WAIT_BUS.
  - If rx_receiving is high in IDLE (unsolicited frame), stay in IDLE with cmd_ready=0 until it drops.
- WAIT_BUS: wait until rx_receiving=0, then go to TX_LAUNCH. An ongoing foreign frame is never collided with.
- TX_LAUNCH: one cycle; pad_oe=1, tx_start=1; go to TX_ACTIVE.
- TX_ACTIVE: pad_oe=1; wait for tx_busy falling.
  - tx_busy may rise up to 2 cycles after tx_start; treat tx_busy=0 as done only after tx_busy has been seen high.
  - If expect_reply=0, go to IDLE with done_pulse and pad_oe=0 in the same cycle.
  - Otherwise go to TURNAROUND.
- TURNAROUND: pad_oe=0 and rx_enable=0 for exactly TURNAROUND_CYCLES cycles, counted from entry; then go to WAIT_REPLY.
- WAIT_REPLY: rx_enable=1, and the timeout counter increments each cycle.
  - rx_receiving=1: go to RX_ACTIVE.
  - Counter reaches REPLY_TIMEOUT_CYCLES-1 with no rx_receiving: timeout_pulse=1, go to IDLE.
  - Both in the same cycle: rx_receiving wins, no timeout.
- RX_ACTIVE: rx_enable=1, no timeout.
  - rx_done: done_pulse=1, go to IDLE.
  - rx_receiving falling without rx_done (error/skipped frame): go to IDLE with neither pulse.
- rx_enable is deasserted in the same cycle IDLE is entered.
- cmd_valid outside IDLE is ignored; there is no queueing.
- pad_oe and rx_enable are never 1 simultaneously; this is a design invariant and carries an assertion.
- Latency: cmd_valid accepted at cycle N → tx_start at N+2 when the bus is idle.
- Counters saturate and never wrap.

Optional Feature:
MAPLE_SEQ_RETRY_EN.
- Defined: a reply timeout does not pulse timeout_pulse immediately. The sequencer goes to WAIT_BUS and retransmits, at most 2 retries (3 attempts total). timeout_pulse fires only after the last attempt times out. A 2-bit retry count is cleared in IDLE.
- Undefined: a single attempt, timeout reported immediately, no retry logic synthesized.

Test Plan:
- No-reply TX: cmd_valid with expect_reply=0; tx_busy high for 20 cycles → tx_start at cycle +2, pad_oe high 21 cycles, done_pulse one cycle, rx_enable never 1.
- Reply path: expect_reply=1; tx_busy 20 cycles; rx_receiving rises 10 cycles after rx_enable, rx_done 50 cycles later → pad_oe low exactly 32 cycles before rx_enable=1, done_pulse at rx_done, timeout_pulse never.
- Timeout: expect_reply=1, no reply, REPLY_TIMEOUT_CYCLES=100 → timeout_pulse exactly 100 cycles after rx_enable rises, then IDLE with cmd_ready=1; with MAPLE_SEQ_RETRY_EN, three tx_start pulses then one timeout_pulse.
- Busy bus: rx_receiving=1 when cmd_valid arrives, held 40 cycles → no tx_start until 2 cycles after rx_receiving falls.
- Edge race: rx_receiving rises on the final timeout cycle → RX_ACTIVE entered, no timeout_pulse; receiver drops without rx_done → IDLE, no pulses.
- Reset mid-TX: aresetn low for 1 cycle during TX_ACTIVE → next cycle pad_oe=0, rx_enable=0, busy=0, cmd_ready=1.
